// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions.
// Holds the decoder FSM state encoding and the 16-entry active-low segment
// code table (seg[0]=a .. seg[6]=g). The hex-to-segment display driver uses
// the same table, so that driver and this decoder always agree.
package seg7_pkg;

  // Decoder FSM state encoding. Kept as plain constants so that existing
  // users of this package keep working.
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  localparam int unsigned NUM_CODES = 16;

  // Active-low segment pattern for a hex nibble, as seg[6:0] = g..a.
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0011000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational segment-pattern to nibble lookup.
// Ports:
//   seg    in  7  active-low segment pattern (seg[0]=a .. seg[6]=g)
//   nibble out 4  decoded hex digit (0 when the pattern is illegal)
//   legal  out 1  seg matches one of the 16 table entries
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  // The 16 table entries are distinct, so at most one comparison can hit.
  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      if (seg == seg_code(4'(i))) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder and digit packer.
// Consumes active-low segment patterns, decodes each to a hex nibble and
// packs DIGITS legal nibbles into one word, first digit in the top nibble.
// Illegal patterns are dropped and counted (saturating at 255).
// Ports:
//   clk       in  1          clock, rising edge
//   rst       in  1          synchronous active-high reset
//   seg       in  7          active-low segment pattern
//   in_valid  in  1          seg holds a pattern to consume
//   in_ready  out 1          pattern accepted this cycle (COLLECT)
//   out_word  out 4*DIGITS   packed digits
//   out_valid out 1          out_word complete and stable (HOLD)
//   out_ready in  1          consumer takes out_word this cycle
//   err_cnt   out 8          cumulative illegal-pattern count
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            err_cnt
);

  localparam int unsigned W = 4 * DIGITS;

  logic [0:0]   state;
  logic [3:0]   digit_cnt;
  logic [W-1:0] word_q;
  logic [W-1:0] word_shifted;
  logic [7:0]   err_q;
  logic [3:0]   nibble;
  logic         legal;
  logic         accept;
  logic         last_digit;

  seg7_lookup u_lookup (
    .seg    (seg),
    .nibble (nibble),
    .legal  (legal)
  );

  assign in_ready  = (state == ST_COLLECT);
  assign out_valid = (state == ST_HOLD);
  assign out_word  = word_q;
  assign err_cnt   = err_q;

  assign accept     = in_valid && (state == ST_COLLECT);
  assign last_digit = (digit_cnt == 4'(DIGITS - 1));

  // Shift-then-OR keeps the DIGITS=1 case free of an empty slice.
  always_comb begin
    word_shifted = (word_q << 4) | W'(nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COLLECT;
      digit_cnt <= '0;
      word_q    <= '0;
      err_q     <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            if (legal) begin
              word_q    <= word_shifted;
              digit_cnt <= digit_cnt + 4'd1;
              if (last_digit) begin
                state <= ST_HOLD;
              end
            end else if (err_q != '1) begin
              err_q <= err_q + 8'd1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            state     <= ST_COLLECT;
            digit_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
module tb_seg7_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg4, seg1;
  logic        iv4, iv1, ordy4, ordy1;
  logic        ir4, ir1, ov4, ov1;
  logic [15:0] word4;
  logic [3:0]  word1;
  logic [7:0]  err4, err1;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;

  logic [6:0] codes [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [6:0]  bad [3] = '{7'b1111111, 7'b1111110, 7'b0000001};
  logic [15:0] words [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

  always #5 clk = ~clk;

  seg7_decoder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .seg(seg4), .in_valid(iv4), .in_ready(ir4),
    .out_word(word4), .out_valid(ov4), .out_ready(ordy4), .err_cnt(err4)
  );

  seg7_decoder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .seg(seg1), .in_valid(iv1), .in_ready(ir1),
    .out_word(word1), .out_valid(ov1), .out_ready(ordy1), .err_cnt(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; counts dut4 acceptances seen just before the edge.
  task automatic step();
    if (iv4 && ir4) accepted++;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake4();
    ordy4 = 1'b1;
    step();
    ordy4 = 1'b0;
    check("hs_in_ready", 32'(ir4), 32'd1);
    check("hs_out_valid", 32'(ov4), 32'd0);
  endtask

  initial begin
    rst = 1'b1; seg4 = '1; seg1 = '1; iv4 = 0; iv1 = 0; ordy4 = 0; ordy1 = 0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(ir4), 32'd1);
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_out_word", 32'(word4), 32'h0);
    check("rst_err_cnt", 32'(err4), 32'd0);

    // 1,2,3,4 back to back
    iv4 = 1;
    seg4 = codes[1]; step();
    seg4 = codes[2]; step();
    seg4 = codes[3]; step();
    check("w1234_not_yet_valid", 32'(ov4), 32'd0);
    seg4 = codes[4]; step();
    iv4 = 0;
    check("w1234_out_valid", 32'(ov4), 32'd1);
    check("w1234_word", 32'(word4), 32'h1234);
    check("w1234_err", 32'(err4), 32'd0);
    handshake4();

    // A, illegal, B, C, D
    accepted = 0;
    iv4 = 1;
    seg4 = 7'b0001000; step();
    seg4 = 7'b1111111; step();
    seg4 = 7'b0000011; step();
    seg4 = 7'b1000110; step();
    check("wabcd_not_yet_valid", 32'(ov4), 32'd0);
    seg4 = 7'b0100001; step();
    check("wabcd_out_valid", 32'(ov4), 32'd1);
    check("wabcd_word", 32'(word4), 32'hABCD);
    check("wabcd_err", 32'(err4), 32'd1);
    check("wabcd_accepted", 32'(accepted), 32'd5);

    // HOLD stability with garbage input
    for (int i = 0; i < 10; i++) begin
      seg4 = 7'($urandom);
      step();
      check("hold_in_ready", 32'(ir4), 32'd0);
      check("hold_word", 32'(word4), 32'hABCD);
      check("hold_err", 32'(err4), 32'd1);
    end
    iv4 = 0;
    handshake4();

    // Reset mid-word; out_ready asserted during COLLECT must be ignored
    iv4 = 1;
    seg4 = codes[5]; step();
    seg4 = codes[6]; step();
    iv4 = 0;
    rst = 1; step(); rst = 0;
    check("midrst_err", 32'(err4), 32'd0);
    check("midrst_word", 32'(word4), 32'h0);
    check("midrst_in_ready", 32'(ir4), 32'd1);
    iv4 = 1; ordy4 = 1;
    seg4 = codes[0]; step();
    seg4 = codes[0]; step();
    seg4 = codes[0]; step();
    ordy4 = 0;
    check("ign_ordy_not_valid", 32'(ov4), 32'd0);
    seg4 = codes[8]; step();
    iv4 = 0;
    check("w0008_out_valid", 32'(ov4), 32'd1);
    check("w0008_word", 32'(word4), 32'h0008);
    handshake4();

    // 300 illegal patterns -> saturate at 255
    iv4 = 1;
    for (int i = 0; i < 300; i++) begin
      seg4 = bad[i % 3];
      step();
      if (i == 253) check("err_254", 32'(err4), 32'd254);
      if (i == 254) check("err_255", 32'(err4), 32'd255);
    end
    check("err_sat", 32'(err4), 32'd255);
    check("err_sat_in_ready", 32'(ir4), 32'd1);

    // All 16 legal codes across 4 words
    for (int w = 0; w < 4; w++) begin
      iv4 = 1;
      for (int d = 0; d < 4; d++) begin
        seg4 = codes[w * 4 + d];
        step();
      end
      iv4 = 0;
      check("all16_out_valid", 32'(ov4), 32'd1);
      check("all16_word", 32'(word4), 32'(words[w]));
      handshake4();
    end
    check("all16_err", 32'(err4), 32'd255);

    // DIGITS=1: F, then accept immediately after handshake
    iv1 = 1; seg1 = 7'b0001110; step();
    check("d1_out_valid", 32'(ov1), 32'd1);
    check("d1_word_F", 32'(word1), 32'hF);
    seg1 = codes[1];
    step();
    check("d1_hold_in_ready", 32'(ir1), 32'd0);
    check("d1_hold_word", 32'(word1), 32'hF);
    ordy1 = 1; step(); ordy1 = 0;
    check("d1_hs_in_ready", 32'(ir1), 32'd1);
    step();
    iv1 = 0;
    check("d1_next_valid", 32'(ov1), 32'd1);
    check("d1_next_word", 32'(word1), 32'h1);
    check("d1_err", 32'(err1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of decoded digits packed per output word (legal values 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port seg  input  7  active-low segment pattern; seg[0]=a … seg[6]=g.
REQ-005 SHALL have port in_valid  input  1  seg holds a pattern to consume.
REQ-006 SHALL have port in_ready  output  1  block accepts seg this cycle.
REQ-007 SHALL have port out_word  output  4*DIGITS  packed digits; first-accepted digit in the most significant nibble.
REQ-008 SHALL have port out_valid  output  1  out_word is complete and stable.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_word this cycle.
REQ-010 SHALL have port err_cnt  output  8  count of illegal patterns received.

Function
REQ-011 SHALL decode exactly this table (seg[6:0] -> nibble), and nothing else: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-012 SHALL treat any of the remaining 112 patterns as illegal.
REQ-013 SHALL use a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a pattern only on a cycle with in_valid=1 and in_ready=1.
REQ-015 SHALL, on an accepted legal pattern, left-shift the nibble into the word register and increment the digit count.
REQ-016 SHALL, on an accepted illegal pattern, leave the word register and digit count unchanged and increment err_cnt, saturating at 255.
REQ-017 SHALL go COLLECT->HOLD on the edge that accepts the DIGITS-th legal digit, so out_valid is high on the next cycle (latency 1 cycle from that acceptance).
REQ-018 SHALL hold out_word constant while in HOLD, regardless of seg/in_valid.
REQ-019 SHALL go HOLD->COLLECT on a cycle with out_ready=1, clearing the digit count to 0; out_word may retain its stale value.
REQ-020 SHALL be able to accept a new pattern on the cycle immediately after the HOLD->COLLECT handshake, giving one dead cycle per word.
REQ-021 SHALL ignore out_ready while in COLLECT.
REQ-022 SHALL keep err_cnt cumulative across words; err_cnt is cleared only by reset.

Reset
REQ-023 SHALL, on a clock edge with rst=1, enter COLLECT, clear the digit count, and set out_word=0, out_valid=0, in_ready=1 (effective after that edge), and err_cnt=0.
REQ-024 SHALL give rst priority over every simultaneous event, including acceptance and handshake; a partially collected word is discarded.

Structure
REQ-025 SHALL place the FSM state encoding and the 16-entry segment code table in a shared package seg7_pkg, also used by the existing hex-to-segment display driver.
REQ-026 SHALL implement the pattern lookup as one combinational sub-module seg7_lookup (seg in; nibble and legal out), instantiated once.

Verification
REQ-027 Bench SHALL drive 1111001, 0100100, 0110000, 0011001 back-to-back -> out_valid high one cycle after the 4th acceptance, out_word=16'h1234, err_cnt=0.
REQ-028 Bench SHALL drive 0001000, 1111111, 0000011, 1000110, 0100001 -> out_word=16'hABCD, err_cnt=1, and exactly 5 accepted cycles.
REQ-029 Bench SHALL hold out_ready=0 for 10 cycles in HOLD with in_valid=1 and random seg -> in_ready=0 throughout, out_word unchanged, err_cnt unchanged.
REQ-030 Bench SHALL assert rst after 2 digits of a word, then send 4 digits 0,0,0,8 -> out_word=16'h0008.
REQ-031 Bench SHALL send 300 illegal patterns -> err_cnt=255 (saturated); all 16 legal codes across 4 words each decode correctly.
REQ-032 Bench SHALL, with DIGITS=1, drive pattern 0001110 -> out_word=4'hF, and check that a new pattern is accepted one cycle after the handshake.
